// File: rtl/llc_mem_bridge.sv
// LLC line request to word-beat memory bridge.
// Splits line reads/writes into beats and gathers read words into a line response.
module llc_mem_bridge #(
  parameter int WORD_BITS      = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINE_ADDR_BITS = 28,
  parameter int OFF_BITS       = 2,
  parameter int BYTE_OFF_BITS  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           llc_mem_req_valid,
  output logic                           llc_mem_req_ready,
  input  logic                           llc_mem_req_data_hwrite,
  input  logic [2:0]                     llc_mem_req_data_hsize,
  input  logic [1:0]                     llc_mem_req_data_hprot,
  input  logic [LINE_ADDR_BITS-1:0]      llc_mem_req_data_addr,
  input  logic [WORD_BITS*WORDS_PER_LINE-1:0] llc_mem_req_data_line,
  output logic                           llc_mem_rsp_valid,
  input  logic                           llc_mem_rsp_ready,
  output logic [WORD_BITS*WORDS_PER_LINE-1:0] llc_mem_rsp_data_line,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_we,
  output logic [LINE_ADDR_BITS+OFF_BITS+BYTE_OFF_BITS-1:0] mem_req_addr,
  output logic [WORD_BITS-1:0]           mem_req_wdata,
  output logic [1:0]                     mem_req_hprot,
  input  logic                           mem_rsp_valid,
  input  logic [WORD_BITS-1:0]           mem_rsp_rdata,
  output logic                           bridge_err
);

  localparam int LINE_BITS = WORD_BITS * WORDS_PER_LINE;
  localparam int CNT_BITS  = OFF_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WORDS_PER_LINE - 1);
  localparam logic [CNT_BITS-1:0] CNT_END  = CNT_BITS'(WORDS_PER_LINE);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t state, state_nxt;

  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0]      line_q;
  logic [1:0]                hprot_q;
  logic [2:0]                hsize_unused_q;
  logic [CNT_BITS-1:0]       iss_cnt;
  logic [CNT_BITS-1:0]       rcv_cnt;
  logic                      err_q;
  logic [OFF_BITS-1:0]       iss_idx;
  logic [OFF_BITS-1:0]       rcv_idx;
  logic                      req_hs;
  logic                      beat_hs;
  logic                      rsp_ok;

  assign iss_idx = iss_cnt[OFF_BITS-1:0];
  assign rcv_idx = rcv_cnt[OFF_BITS-1:0];
  assign req_hs  = llc_mem_req_valid & llc_mem_req_ready;
  assign beat_hs = mem_req_valid & mem_req_ready;
  // A return is only legal while a read has more beats issued than received.
  assign rsp_ok  = (state == RD) && (rcv_cnt != iss_cnt);

  assign llc_mem_rsp_data_line = line_q;
  assign mem_req_addr  = {addr_q, iss_idx, {BYTE_OFF_BITS{1'b0}}};
  assign mem_req_wdata = line_q[iss_idx*WORD_BITS +: WORD_BITS];
  assign mem_req_hprot = hprot_q;
  assign bridge_err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    llc_mem_req_ready = 1'b0;
    llc_mem_rsp_valid = 1'b0;
    mem_req_valid     = 1'b0;
    mem_req_we        = 1'b0;
    unique case (state)
      IDLE: begin
        llc_mem_req_ready = 1'b1;
        if (llc_mem_req_valid)
          state_nxt = llc_mem_req_data_hwrite ? WR : RD;
      end
      WR: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready && iss_cnt == CNT_LAST)
          state_nxt = IDLE;
      end
      RD: begin
        mem_req_valid = iss_cnt < CNT_END;
        if (mem_rsp_valid && rsp_ok && rcv_cnt == CNT_LAST)
          state_nxt = RSP;
      end
      RSP: begin
        llc_mem_rsp_valid = 1'b1;
        if (llc_mem_rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      line_q         <= '0;
      hprot_q        <= '0;
      hsize_unused_q <= '0;
      iss_cnt        <= '0;
      rcv_cnt        <= '0;
      err_q          <= 1'b0;
    end else begin
      if (req_hs) begin
        addr_q         <= llc_mem_req_data_addr;
        line_q         <= llc_mem_req_data_line;
        hprot_q        <= llc_mem_req_data_hprot;
        hsize_unused_q <= llc_mem_req_data_hsize;
        iss_cnt        <= '0;
        rcv_cnt        <= '0;
      end
      if (beat_hs)
        iss_cnt <= iss_cnt + CNT_ONE;
      if (mem_rsp_valid) begin
        if (rsp_ok) begin
          line_q[rcv_idx*WORD_BITS +: WORD_BITS] <= mem_rsp_rdata;
          rcv_cnt <= rcv_cnt + CNT_ONE;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Bench for llc_mem_bridge: transaction-level model plus word memory responder.
// Directed line reads/writes with stalls, backpressure, stray returns and reset.
module tb_llc_mem_bridge;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int AB = 28;
  localparam int LB = W * N;
  localparam int MB = AB + 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          llc_mem_req_valid = 1'b0;
  logic          llc_mem_req_ready;
  logic          llc_mem_req_data_hwrite = 1'b0;
  logic [2:0]    llc_mem_req_data_hsize = '0;
  logic [1:0]    llc_mem_req_data_hprot = '0;
  logic [AB-1:0] llc_mem_req_data_addr = '0;
  logic [LB-1:0] llc_mem_req_data_line = '0;
  logic          llc_mem_rsp_valid;
  logic          llc_mem_rsp_ready = 1'b1;
  logic [LB-1:0] llc_mem_rsp_data_line;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic          mem_req_we;
  logic [MB-1:0] mem_req_addr;
  logic [W-1:0]  mem_req_wdata;
  logic [1:0]    mem_req_hprot;
  logic          mem_rsp_valid = 1'b0;
  logic [W-1:0]  mem_rsp_rdata = '0;
  logic          bridge_err;

  llc_mem_bridge dut (
    .clk(clk), .rst(rst),
    .llc_mem_req_valid(llc_mem_req_valid),
    .llc_mem_req_ready(llc_mem_req_ready),
    .llc_mem_req_data_hwrite(llc_mem_req_data_hwrite),
    .llc_mem_req_data_hsize(llc_mem_req_data_hsize),
    .llc_mem_req_data_hprot(llc_mem_req_data_hprot),
    .llc_mem_req_data_addr(llc_mem_req_data_addr),
    .llc_mem_req_data_line(llc_mem_req_data_line),
    .llc_mem_rsp_valid(llc_mem_rsp_valid),
    .llc_mem_rsp_ready(llc_mem_rsp_ready),
    .llc_mem_rsp_data_line(llc_mem_rsp_data_line),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_req_hprot(mem_req_hprot),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata),
    .bridge_err(bridge_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [LB-1:0] act, logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           ep;
  } ret_t;

  logic [W-1:0] mem [int unsigned];
  ret_t rq[$];

  bit            mon_on = 0;
  bit            busy = 0;
  bit            is_wr = 0;
  int            issued = 0;
  int            returned = 0;
  logic [AB-1:0] m_addr = '0;
  logic [LB-1:0] m_line = '0;
  logic [1:0]    m_hprot = '0;
  bit            err_exp = 0;
  int            epoch = 0;
  int            stall_beat = -1;
  int            stall_len = 0;
  int            stall_done = 0;
  bit            spur = 0;
  int            beats_seen = 0;
  int            acc_cnt = 0;
  int            rsp_seen = 0;
  logic [LB-1:0] last_rsp = '0;
  logic [MB-1:0] first_addr = '0;
  bit            cap_first = 0;
  bit            rsp_first = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  int            rsp_lat = 0;

  function automatic logic [W-1:0] mem_rd(logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Model + memory responder; decisions here take effect at the next posedge.
  always @(negedge clk) begin
    ret_t r;
    bit ok, hs, acc, err_nxt;
    logic [31:0] ea;
    cyc++;
    if (mon_on) begin
      chk("req_ready", llc_mem_req_ready, !busy);
      chk("rsp_valid", llc_mem_rsp_valid, busy && !is_wr && returned == N);
      chk("beat_valid", mem_req_valid, busy && issued < N);
      chk("bridge_err", bridge_err, err_exp);
      if (busy && issued < N) begin
        ea = 32'(m_addr) * 16 + 32'(issued * 4);
        chk("beat_addr", mem_req_addr, ea);
        chk("beat_we", mem_req_we, is_wr);
        chk("beat_hprot", mem_req_hprot, m_hprot);
        if (is_wr) chk("beat_wdata", mem_req_wdata, m_line[issued*W +: W]);
      end
      if (busy && !is_wr && returned == N) begin
        chk("rsp_line", llc_mem_rsp_data_line, m_line);
        if (rsp_first) begin
          rsp_lat = cyc - acc_cyc;
          rsp_first = 0;
        end
      end
    end

    err_nxt = err_exp;
    ok = 0;
    if (rq.size() > 0) begin
      r = rq.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = r.data;
      ok = (r.ep == epoch) && busy && !is_wr && returned < issued;
    end else if (spur) begin
      spur = 0;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'hDEAD_BEEF;
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
    end
    if (mem_rsp_valid && !ok) err_nxt = 1;

    mem_req_ready = 1'b1;
    if (mem_req_valid && issued == stall_beat && stall_done < stall_len) begin
      mem_req_ready = 1'b0;
      stall_done++;
    end
    hs  = mem_req_valid && mem_req_ready;
    acc = llc_mem_req_valid && llc_mem_req_ready;

    if (ok) returned++;
    if (hs) begin
      beats_seen++;
      if (cap_first) begin
        first_addr = mem_req_addr;
        cap_first = 0;
      end
      if (mem_req_we) begin
        mem[mem_req_addr] = mem_req_wdata;
      end else begin
        r.data = mem_rd(mem_req_addr);
        r.ep = epoch;
        rq.push_back(r);
      end
      issued++;
      if (is_wr && issued == N) busy = 0;
    end
    if (llc_mem_rsp_valid && llc_mem_rsp_ready) begin
      busy = 0;
      rsp_seen++;
      last_rsp = llc_mem_rsp_data_line;
    end
    if (acc) begin
      busy = 1;
      is_wr = llc_mem_req_data_hwrite;
      issued = 0;
      returned = 0;
      m_addr = llc_mem_req_data_addr;
      m_hprot = llc_mem_req_data_hprot;
      acc_cnt++;
      acc_cyc = cyc;
      rsp_first = 1;
      cap_first = 1;
      if (is_wr) begin
        m_line = llc_mem_req_data_line;
      end else begin
        for (int i = 0; i < N; i++)
          m_line[i*W +: W] = mem_rd(32'(m_addr) * 16 + 32'(i * 4));
      end
    end
    if (rst) begin
      busy = 0;
      err_nxt = 0;
      epoch++;
    end
    err_exp = err_nxt;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_req(bit wr, logic [AB-1:0] a, logic [LB-1:0] l, logic [1:0] hp);
    int a0;
    a0 = acc_cnt;
    llc_mem_req_valid = 1'b1;
    llc_mem_req_data_hwrite = wr;
    llc_mem_req_data_hsize = 3'd4;
    llc_mem_req_data_hprot = hp;
    llc_mem_req_data_addr = a;
    llc_mem_req_data_line = l;
    for (int i = 0; i < 100 && acc_cnt == a0; i++) step();
    chk("accept", acc_cnt != a0, 1);
    llc_mem_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("idle_timeout", busy || rq.size() != 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, b0, n;
    mem[32'h100] = 32'h11; mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33; mem[32'h10C] = 32'h44;
    mem[32'h300] = 32'hA0; mem[32'h304] = 32'hB1;
    mem[32'h308] = 32'hC2; mem[32'h30C] = 32'hD3;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    mon_on = 1;
    chk("rst_req_ready", llc_mem_req_ready, 1);
    chk("rst_rsp_valid", llc_mem_rsp_valid, 0);
    chk("rst_mem_valid", mem_req_valid, 0);
    chk("rst_err", bridge_err, 0);

    do_req(0, 28'h0000010, '0, 2'b01);
    wait_idle();
    chk("t1_line", last_rsp, 128'h00000044_00000033_00000022_00000011);
    chk("t1_first_addr", first_addr, 32'h100);
    chk("t1_latency", rsp_lat, 6);

    r0 = rsp_seen;
    do_req(1, 28'h0000020, 128'h0000000D_0000000C_0000000B_0000000A, 2'b10);
    wait_idle();
    chk("t2_w0", mem_rd(32'h200), 32'hA);
    chk("t2_w1", mem_rd(32'h204), 32'hB);
    chk("t2_w2", mem_rd(32'h208), 32'hC);
    chk("t2_w3", mem_rd(32'h20C), 32'hD);
    chk("t2_no_rsp", rsp_seen, r0);
    chk("t2_ready", llc_mem_req_ready, 1);

    stall_beat = 2; stall_len = 3; stall_done = 0;
    b0 = beats_seen;
    do_req(0, 28'h0000030, '0, 2'b00);
    wait_idle();
    chk("t3_rd_line", last_rsp, 128'h000000D3_000000C2_000000B1_000000A0);
    chk("t3_rd_beats", beats_seen - b0, 4);
    chk("t3_rd_stalls", stall_done, 3);
    stall_done = 0;
    b0 = beats_seen;
    do_req(1, 28'h0000040, 128'h44440004_33330003_22220002_11110001, 2'b11);
    wait_idle();
    chk("t3_wr_beats", beats_seen - b0, 4);
    chk("t3_w1", mem_rd(32'h404), 32'h22220002);
    chk("t3_w2", mem_rd(32'h408), 32'h33330003);
    chk("t3_w3", mem_rd(32'h40C), 32'h44440004);
    stall_beat = -1;

    llc_mem_rsp_ready = 1'b0;
    do_req(0, 28'h0000010, '0, 2'b11);
    n = 0;
    while (!llc_mem_rsp_valid && n < 100) begin step(); n++; end
    chk("t4_rsp_seen", llc_mem_rsp_valid, 1);
    repeat (5) begin
      step();
      chk("t4_hold_valid", llc_mem_rsp_valid, 1);
      chk("t4_req_blocked", llc_mem_req_ready, 0);
    end
    llc_mem_rsp_ready = 1'b1;
    wait_idle();
    chk("t4_line", last_rsp, 128'h00000044_00000033_00000022_00000011);

    spur = 1;
    repeat (3) step();
    chk("t5_err_set", bridge_err, 1);
    do_req(0, 28'h0000010, '0, 2'b01);
    wait_idle();
    chk("t5_line", last_rsp, 128'h00000044_00000033_00000022_00000011);
    chk("t5_err_sticky", bridge_err, 1);

    b0 = beats_seen;
    r0 = rsp_seen;
    do_req(0, 28'h0000030, '0, 2'b00);
    n = 0;
    while (beats_seen < b0 + 2 && n < 100) begin step(); n++; end
    chk("t6_two_beats", beats_seen >= b0 + 2, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_req_ready", llc_mem_req_ready, 1);
    chk("t6_rsp_valid", llc_mem_rsp_valid, 0);
    chk("t6_mem_valid", mem_req_valid, 0);
    repeat (4) step();
    chk("t6_no_rsp", rsp_seen, r0);
    do_req(0, 28'h0000030, '0, 2'b10);
    wait_idle();
    chk("t6_line", last_rsp, 128'h000000D3_000000C2_000000B1_000000A0);

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
